// File: rtl/butterfly_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with a single-entry valid/ready response slot.
package butterfly_pkg;
  parameter int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [4:0]      reg_addr_t;
endpackage

module butterfly_muldiv #(
  parameter int XLEN = butterfly_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rd,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

  // neg: sign of product/quotient, rneg: sign of remainder (follows rs1)
  typedef struct packed {
    logic [1:0] op;
    logic [4:0] rd;
    logic       neg;
    logic       rneg;
  } ctx_t;

  logic [1:0]        state;
  ctx_t              ctx;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand;
  logic [XLEN-1:0]   opa, opb;

  assign req_ready  = (state == S_IDLE) && !flush;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  // operand decode on the request
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed    = req_op[2] ? ~req_op[0] : (req_op[1:0] == 2'b01 || req_op[1:0] == 2'b10);
    b_signed    = req_op[2] ? ~req_op[0] : (req_op[1:0] == 2'b01);
    a_neg       = a_signed & req_rs1[XLEN-1];
    b_neg       = b_signed & req_rs2[XLEN-1];
    a_mag       = a_neg ? -req_rs1 : req_rs1;
    b_mag       = b_neg ? -req_rs2 : req_rs2;
    div_zero    = req_op[2] && (req_rs2 == '0);
    div_ovf     = req_op[2] && !req_op[0] && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                  && (req_rs2 == '1);
    special_res = '0;
    if (div_zero)     special_res = req_op[1] ? req_rs1 : '1;
    else if (div_ovf) special_res = req_op[1] ? '0 : req_rs1;
  end

  // one iteration step plus sign-corrected final result
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN:0]     r_try, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_nx, quo_nx, mul_res, div_res;
  logic              last;

  always_comb begin
    acc_nx  = opb[0] ? acc + mcand : acc;
    prod    = ctx.neg ? -acc_nx : acc_nx;
    mul_res = (ctx.op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    r_try   = {acc[XLEN-1:0], opa[XLEN-1]};
    diff    = r_try - {1'b0, opb};
    ge      = !diff[XLEN];
    rem_nx  = ge ? diff[XLEN-1:0] : r_try[XLEN-1:0];
    quo_nx  = {opa[XLEN-2:0], ge};
    div_res = ctx.op[1] ? (ctx.rneg ? -rem_nx : rem_nx) : (ctx.neg ? -quo_nx : quo_nx);
    last    = (cnt == CW'(XLEN-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ctx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      opa       <= '0;
      opb       <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          ctx   <= '{op: req_op[1:0], rd: req_rd, neg: a_neg ^ b_neg, rneg: a_neg};
          cnt   <= '0;
          acc   <= '0;
          mcand <= {{XLEN{1'b0}}, a_mag};
          opa   <= a_mag;
          opb   <= b_mag;
          if (div_zero || div_ovf) begin
            resp_data <= special_res;
            resp_rd   <= req_rd;
            state     <= S_DONE;
          end else begin
            state <= req_op[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          acc   <= acc_nx;
          mcand <= mcand << 1;
          opb   <= opb >> 1;
          cnt   <= cnt + CW'(1);
          if (last) begin
            resp_data <= mul_res;
            resp_rd   <= ctx.rd;
            state     <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= {{XLEN{1'b0}}, rem_nx};
          opa <= quo_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            resp_data <= div_res;
            resp_rd   <= ctx.rd;
            state     <= S_DONE;
          end
        end
        default: if (resp_ready) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_butterfly_muldiv.sv
// Directed bench for butterfly_muldiv: RV32M vectors, latency, hold, flush, reset.
module tb_butterfly_muldiv;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  butterfly_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  int errs = 0, nchk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd;
  endtask

  // edges counted from and including the acceptance edge
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      req_valid = 1'b0;
    end while (!resp_valid && n < 100);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, "_valid_after"}, {31'b0, resp_valid}, 32'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int lat);
    int n;
    issue(op, a, b, rd);
    wait_resp(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_rd"}, {27'b0, resp_rd}, {27'b0, rd});
    handshake(tag);
  endtask

  initial begin
    int n, seen;
    logic [31:0] d0;
    logic [4:0]  r0;

    // reset state
    #12;
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_rd", {27'b0, resp_rd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);

    // multiply: 32 iteration edges after acceptance
    run("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
    run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33);
    run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33);
    run("mul_m1", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001, 33);
    // divide
    run("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd17, 32'hFFFF_FFFD, 33);
    run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd18, 32'hFFFF_FFFF, 33);
    run("divu",   3'b101, 32'd100,       32'd7,         5'd17, 32'd14,        33);
    run("remu",   3'b111, 32'd100,       32'd7,         5'd19, 32'd2,         33);
    // divide by zero and signed overflow complete on the acceptance edge
    run("divu0",  3'b101, 32'd5,         32'd0,         5'd20, 32'hFFFF_FFFF, 1);
    run("remu0",  3'b111, 32'd5,         32'd0,         5'd21, 32'd5,         1);
    run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1);
    run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'd0,         1);

    // response held while consumer stalls; a pending request is not taken
    issue(3'b101, 32'd100, 32'd7, 5'd9);
    wait_resp(n);
    chk("hold_lat", n, 33);
    d0 = resp_data; r0 = resp_rd;
    chk("hold_data0", d0, 32'd14);
    req_valid = 1'b1; req_op = 3'b000; req_rs1 = 32'd3; req_rs2 = 32'd3; req_rd = 5'd30;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_data", resp_data, 32'd14);
      chk("hold_rd", {27'b0, resp_rd}, 32'd9);
      chk("hold_ready", {31'b0, req_ready}, 32'd0);
      chk("hold_busy", {31'b0, busy}, 32'd1);
    end
    req_valid = 1'b0;
    handshake("hold");
    chk("hold_rd_kept", {27'b0, resp_rd}, {27'b0, r0});

    // flush during a divide
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11);
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    chk("flush_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_valid", {31'b0, resp_valid}, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
    chk("flush_no_resp", seen, 0);

    // reset in the middle of a multiply
    issue(3'b000, 32'd7, 32'd3, 5'd3);
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2; rst_n = 1'b0; #1;
    chk("mrst_valid", {31'b0, resp_valid}, 32'd0);
    chk("mrst_busy", {31'b0, busy}, 32'd0);
    chk("mrst_data", resp_data, 32'd0);
    chk("mrst_rd", {27'b0, resp_rd}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
    chk("mrst_no_resp", seen, 0);

    run("recover", 3'b000, 32'd7, 32'd3, 5'd6, 32'd21, 33);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule

// File: doc/butterfly_muldiv.md
BUTTERFLY_MULDIV -- requirements
Module: butterfly_muldiv

Interface
REQ-001 Parameter: XLEN, default 32 (butterfly_pkg::XLEN); operand and result width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 req_rs1  input  XLEN  operand A (word_t).
REQ-008 req_rs2  input  XLEN  operand B (word_t).
REQ-009 req_rd  input  5  destination register (reg_addr_t), returned unchanged.
REQ-010 flush  input  1  synchronous abort of any operation in progress.
REQ-011 resp_valid  output  1  result available.
REQ-012 resp_ready  input  1  consumer accepts result.
REQ-013 resp_data  output  XLEN  result.
REQ-014 resp_rd  output  5  destination register of the result.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, MUL, DIV, DONE.
REQ-017 req_ready SHALL be 1 only in IDLE with flush=0; the request is accepted on an edge where req_valid && req_ready.
REQ-018 On acceptance, the unit latches op, rd, operand magnitudes and result sign, clears the iteration counter, and enters MUL (op[2]=0) or DIV (op[2]=1).
REQ-019 MUL: shift-add on magnitudes, one bit per edge into a 2*XLEN accumulator; MULH/MULHSU treat rs1 as signed, MULH treats rs2 as signed, MULHSU/MULHU treat rs2 as unsigned, MULHU treats both as unsigned.
REQ-020 DIV: restoring division on magnitudes, one quotient bit per edge; DIV/REM signed, DIVU/REMU unsigned.
REQ-021 The XLEN-th iteration edge SHALL write the final, sign-corrected result to resp_data and enter DONE; resp_valid rises exactly XLEN edges after the acceptance edge (32 for the default).
REQ-022 Result selection: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; quotient negated if operand signs differ (signed ops only); remainder takes the sign of rs1.
REQ-023 Divide by zero (rs2=0): acceptance edge enters DONE directly; quotient = all ones; remainder = rs1; 1-edge latency.
REQ-024 Signed overflow (DIV/REM, rs1 = 0x8000_0000, rs2 = 0xFFFF_FFFF): acceptance edge enters DONE directly; quotient = 0x8000_0000; remainder = 0.
REQ-025 DONE: resp_valid=1; resp_data and resp_rd are held stable until resp_valid && resp_ready; then return to IDLE on that edge.
REQ-026 No new request is accepted in the response-handshake cycle; minimum spacing between acceptances is latency + 1 edge.
REQ-027 flush=1 in any state: the next edge enters IDLE, clears resp_valid, and discards the result; flush overrides req_valid and resp_ready in the same cycle.
REQ-028 resp_data and resp_rd are undefined-free: they change only on a result write or on reset.

Reset
REQ-029 While rst_n=0, and asynchronously on its assertion: state=IDLE, resp_valid=0, resp_data=0, resp_rd=0, busy=0, counter=0; req_ready=1 from the first edge after release.
REQ-030 Reset asserted mid-operation SHALL abandon the operation; no resp_valid appears after release.

Verification
REQ-031 MUL 7 x 0xFFFF_FFFD -> resp_data 0xFFFF_FFEB, resp_valid 32 edges after acceptance; MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000.
REQ-032 MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF; MULHU with the same operands -> 0xFFFF_FFFE; MUL -> 0x0000_0001.
REQ-033 DIV 0xFFFF_FFF9 / 2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU 100 / 7 -> 14; REMU -> 2; resp_rd equals req_rd (e.g. 5'd17).
REQ-034 DIVU 5 / 0 -> 0xFFFF_FFFF and REMU 5 / 0 -> 5, both after 1 edge; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 and REM -> 0, both after 1 edge.
REQ-035 Hold resp_ready=0 for 5 cycles in DONE -> resp_data and resp_rd stable, req_ready=0, busy=1; on the handshake edge the unit returns to IDLE.
REQ-036 flush at cycle 10 of a DIV -> IDLE on the next edge with no resp_valid; rst_n pulsed mid-MUL -> outputs immediately at reset values.
